// File: rtl/retire_trace_fifo_if.sv
// Retire/trace bundle for retire_trace_fifo.
//   retire_* : one retired-instruction record per cycle from the core
//   trace_*  : first-word-fall-through head record plus drain handshake
//   level_o, retire_count_o, drop_count_o, overflow_o : occupancy and loss status
// slave modport is the FIFO's view; master modport is the core/drain side.
interface retire_trace_fifo_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic            retire_valid_i;
    logic [XLEN-1:0] retire_pc_i;
    logic [XLEN-1:0] retire_instr_i;
    logic [4:0]      retire_rd_i;
    logic [XLEN-1:0] retire_rd_data_i;
    logic [XLEN-1:0] retire_mem_addr_i;
    logic [XLEN-1:0] retire_mem_data_i;
    logic            retire_mem_wrt_i;

    logic            trace_valid_o;
    logic            trace_ready_i;
    logic [XLEN-1:0] trace_pc_o;
    logic [XLEN-1:0] trace_instr_o;
    logic [4:0]      trace_rd_o;
    logic [XLEN-1:0] trace_rd_data_o;
    logic [XLEN-1:0] trace_mem_addr_o;
    logic [XLEN-1:0] trace_mem_data_o;
    logic            trace_mem_wrt_o;

    logic [LW-1:0]   level_o;
    logic [XLEN-1:0] retire_count_o;
    logic [15:0]     drop_count_o;
    logic            overflow_o;

    modport slave (
        input  retire_valid_i, retire_pc_i, retire_instr_i, retire_rd_i,
               retire_rd_data_i, retire_mem_addr_i, retire_mem_data_i,
               retire_mem_wrt_i, trace_ready_i,
        output trace_valid_o, trace_pc_o, trace_instr_o, trace_rd_o,
               trace_rd_data_o, trace_mem_addr_o, trace_mem_data_o,
               trace_mem_wrt_o, level_o, retire_count_o, drop_count_o,
               overflow_o
    );

    modport master (
        output retire_valid_i, retire_pc_i, retire_instr_i, retire_rd_i,
               retire_rd_data_i, retire_mem_addr_i, retire_mem_data_i,
               retire_mem_wrt_i, trace_ready_i,
        input  trace_valid_o, trace_pc_o, trace_instr_o, trace_rd_o,
               trace_rd_data_o, trace_mem_addr_o, trace_mem_data_o,
               trace_mem_wrt_o, level_o, retire_count_o, drop_count_o,
               overflow_o
    );
endinterface

// File: rtl/retire_trace_fifo.sv
// Retire trace FIFO: buffers sanitised retire records for a trace drain port.
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_i   : asynchronous active-high reset (control state only)
//   clear_i : synchronous clear, wins over a same-cycle push/pop
//   bus     : retire_trace_fifo_if.slave (retire input, trace FWFT output, status)
// DEPTH must be a power of two >= 2 so pointers wrap by natural overflow.
module retire_trace_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    retire_trace_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] rd_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic [4:0]      rd;
        logic            mem_wrt;
    } rec_t;

    // Branches and stores write no register; non-store records carry no
    // meaningful memory payload. Zero those fields so the trace is canonical.
    function automatic rec_t sanitise(input rec_t r);
        rec_t s;
        s = r;
        if (r.instr[6:0] == 7'b1100011 || r.instr[6:0] == 7'b0100011) begin
            s.rd      = 5'd0;
            s.rd_data = '0;
        end
        if (!r.mem_wrt) begin
            s.mem_addr = '0;
            s.mem_data = '0;
        end
        return s;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    rec_t            mem [DEPTH];
    rec_t            in_rec;
    rec_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [XLEN-1:0] retire_count;
    logic [15:0]     drop_count;
    logic            overflow;

    logic rec_valid;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        in_rec = sanitise('{
            pc:       bus.retire_pc_i,
            instr:    bus.retire_instr_i,
            rd_data:  bus.retire_rd_data_i,
            mem_addr: bus.retire_mem_addr_i,
            mem_data: bus.retire_mem_data_i,
            rd:       bus.retire_rd_i,
            mem_wrt:  bus.retire_mem_wrt_i
        });
    end

    // An all-zero instruction is a pipeline bubble, not a retirement.
    assign rec_valid = bus.retire_valid_i && (bus.retire_instr_i != '0);
    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = !empty && bus.trace_ready_i;
    // When full, a same-edge pop frees the slot the push lands in.
    assign push      = rec_valid && (!full || pop);
    assign drop      = rec_valid && full && !pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            retire_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else if (clear_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            retire_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (rec_valid) retire_count <= retire_count + 1'b1;
            if (drop) begin
                drop_count <= sat_inc16(drop_count);
                overflow   <= 1'b1;
            end
        end
    end

    // Storage is data only; stale contents are invisible once level is zero.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) mem[wr_ptr] <= in_rec;
    end

    assign head                 = mem[rd_ptr];
    assign bus.trace_valid_o    = !empty;
    assign bus.trace_pc_o       = head.pc;
    assign bus.trace_instr_o    = head.instr;
    assign bus.trace_rd_o       = head.rd;
    assign bus.trace_rd_data_o  = head.rd_data;
    assign bus.trace_mem_addr_o = head.mem_addr;
    assign bus.trace_mem_data_o = head.mem_data;
    assign bus.trace_mem_wrt_o  = head.mem_wrt;
    assign bus.level_o          = level;
    assign bus.retire_count_o   = retire_count;
    assign bus.drop_count_o     = drop_count;
    assign bus.overflow_o       = overflow;
endmodule
